// File: rtl/spi_front_end.sv
// rtl/spi_front_end.sv - SPI mode 0 slave front end: pin sync, frame deserialiser, MISO serialiser
`ifndef SPI_DATA_W
`define SPI_DATA_W 32
`endif

module spi_front_end #(
   parameter int DATA_W = `SPI_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              ss,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] word_in,
   output logic [DATA_W-1:0] word_out,
   output logic              ss_pos_edge,
   output logic              ss_neg_edge,
   output logic              frame_err
);
   localparam int               CNT_W    = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

   logic [2:0]        ss_s;
   logic [2:0]        sclk_s;
   logic [1:0]        mosi_s;
   logic [DATA_W-1:0] rx_sh;
   logic [DATA_W-1:0] tx_sh;
   logic [CNT_W-1:0]  bit_cnt;
   logic              ss_rise, ss_fall, sck_rise, sck_fall, active;

   assign ss_rise  =  ss_s[1]   & ~ss_s[2];
   assign ss_fall  = ~ss_s[1]   &  ss_s[2];
   assign sck_rise =  sclk_s[1] & ~sclk_s[2];
   assign sck_fall = ~sclk_s[1] &  sclk_s[2];
   assign active   = ~ss_s[1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ss_s        <= 3'b111;
         sclk_s      <= '0;
         mosi_s      <= '0;
         rx_sh       <= '0;
         tx_sh       <= '0;
         bit_cnt     <= '0;
         word_out    <= '0;
         miso        <= 1'b0;
         miso_oe     <= 1'b0;
         ss_pos_edge <= 1'b0;
         ss_neg_edge <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         ss_s   <= {ss_s[1:0], ss};
         sclk_s <= {sclk_s[1:0], sclk};
         mosi_s <= {mosi_s[0], mosi};

         // Frame start load takes priority over any coincident sclk edge.
         if (ss_fall) begin
            bit_cnt <= '0;
            tx_sh   <= word_in;
         end else begin
            if (sck_rise && active) begin
               rx_sh <= {rx_sh[DATA_W-2:0], mosi_s[1]};
               if (bit_cnt != CNT_SAT)
                  bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (sck_fall && active)
               tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
         end

         miso    <= active ? tx_sh[DATA_W-1] : 1'b0;
         miso_oe <= active;

         ss_neg_edge <= ss_fall;
         ss_pos_edge <= ss_rise;
         frame_err   <= ss_rise && (bit_cnt != CNT_FULL);
         if (ss_rise && (bit_cnt == CNT_FULL))
            word_out <= rx_sh;
      end
   end
endmodule

// File: tb/tb_spi_front_end.sv
// tb/tb_spi_front_end.sv - randomized self-checking bench for spi_front_end
module tb_spi_front_end;
   logic        clk = 1'b0;
   logic        rst, sclk, ss, mosi;
   logic        miso, miso_oe, ss_pos_edge, ss_neg_edge, frame_err;
   logic [31:0] word_in, word_out;

   int          tests = 0;
   int          fails = 0;
   int          neg_cnt = 0;
   int          err_orphan = 0;
   int          oe_bad = 0;
   logic [31:0] pos_words[$];
   logic        pos_errs[$];
   logic [31:0] model_word = '0;

   spi_front_end #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .word_in(word_in), .word_out(word_out),
      .ss_pos_edge(ss_pos_edge), .ss_neg_edge(ss_neg_edge), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ss_neg_edge) neg_cnt++;
      if (ss_pos_edge) begin
         pos_words.push_back(word_out);
         pos_errs.push_back(frame_err);
      end
      if (frame_err && !ss_pos_edge) err_orphan++;
   end

   initial begin
      #5ms;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic clear_mon;
      neg_cnt = 0;
      err_orphan = 0;
      oe_bad = 0;
      pos_words.delete();
      pos_errs.delete();
   endtask

   // Master side of one mode-0 frame; returns the miso bits it sampled on each sclk rise.
   task automatic send_frame(input int n, input logic [63:0] data, input logic [31:0] tx_word,
                             input int gap, output logic [63:0] rx);
      rx = '0;
      word_in = tx_word;
      @(negedge clk);
      ss = 1'b0;
      repeat (6) @(negedge clk);
      word_in = $urandom;
      for (int i = n - 1; i >= 0; i--) begin
         mosi = data[i];
         repeat (4) @(negedge clk);
         sclk = 1'b1;
         rx = {rx[62:0], miso};
         if (miso_oe !== 1'b1) oe_bad++;
         repeat (4) @(negedge clk);
         sclk = 1'b0;
      end
      repeat (4) @(negedge clk);
      ss = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   function automatic logic [63:0] exp_miso(input int n, input logic [31:0] w);
      logic [63:0] r = '0;
      for (int k = 0; k < n; k++)
         r = {r[62:0], (k < 32) ? w[31 - k] : 1'b0};
      return r;
   endfunction

   task automatic test_reset;
      rst = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; word_in = $urandom;
      repeat (4) @(negedge clk);
      tests++; if (word_out !== 32'h0) begin fails++; $display("FAIL reset_word_out: got %h want 0", word_out); end
      tests++; if (miso !== 1'b0) begin fails++; $display("FAIL reset_miso: got %b want 0", miso); end
      tests++; if (miso_oe !== 1'b0) begin fails++; $display("FAIL reset_miso_oe: got %b want 0", miso_oe); end
      tests++; if (ss_pos_edge !== 1'b0) begin fails++; $display("FAIL reset_pos: got %b want 0", ss_pos_edge); end
      tests++; if (ss_neg_edge !== 1'b0) begin fails++; $display("FAIL reset_neg: got %b want 0", ss_neg_edge); end
      tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", frame_err); end
      rst = 1'b1;
      repeat (8) @(negedge clk);
      tests++;
      if (neg_cnt !== 0 || pos_words.size() !== 0) begin
         fails++; $display("FAIL reset_false_edge: neg %0d pos %0d want 0 0", neg_cnt, pos_words.size());
      end
   endtask

   task automatic test_write;
      logic [63:0] rx;
      clear_mon();
      send_frame(32, 64'h8000_0012, $urandom, 8, rx);
      model_word = 32'h8000_0012;
      tests++; if (neg_cnt !== 1) begin fails++; $display("FAIL write_neg_cnt: got %0d want 1", neg_cnt); end
      tests++;
      if (pos_words.size() !== 1) begin
         fails++; $display("FAIL write_pos_cnt: got %0d want 1", pos_words.size());
      end else begin
         tests++; if (pos_words[0] !== model_word) begin fails++; $display("FAIL write_word: got %h want %h", pos_words[0], model_word); end
         tests++; if (pos_errs[0] !== 1'b0) begin fails++; $display("FAIL write_err: got %b want 0", pos_errs[0]); end
      end
   endtask

   task automatic test_readback;
      logic [63:0] rx;
      clear_mon();
      tests++; if (miso !== 1'b0 || miso_oe !== 1'b0) begin fails++; $display("FAIL rb_idle_pre: miso %b oe %b want 0 0", miso, miso_oe); end
      send_frame(32, {$urandom, $urandom}, 32'hA5A5_0F0F, 8, rx);
      tests++; if (rx[31:0] !== 32'hA5A5_0F0F) begin fails++; $display("FAIL rb_miso: got %h want a5a50f0f", rx[31:0]); end
      tests++; if (oe_bad !== 0) begin fails++; $display("FAIL rb_oe_inside: %0d samples with oe low, want 0", oe_bad); end
      tests++; if (miso !== 1'b0 || miso_oe !== 1'b0) begin fails++; $display("FAIL rb_idle_post: miso %b oe %b want 0 0", miso, miso_oe); end
      if (pos_words.size() == 1) model_word = pos_words[0];
   endtask

   task automatic test_short;
      logic [63:0] rx;
      clear_mon();
      send_frame(32, 64'h1234_5678, $urandom, 8, rx);
      model_word = 32'h1234_5678;
      send_frame(16, {$urandom, $urandom}, $urandom, 8, rx);
      tests++;
      if (pos_words.size() !== 2) begin
         fails++; $display("FAIL short_pos_cnt: got %0d want 2", pos_words.size());
      end else begin
         tests++; if (pos_words[1] !== model_word) begin fails++; $display("FAIL short_word: got %h want %h", pos_words[1], model_word); end
         tests++; if (pos_errs[1] !== 1'b1) begin fails++; $display("FAIL short_err: got %b want 1", pos_errs[1]); end
      end
      tests++; if (err_orphan !== 0) begin fails++; $display("FAIL short_err_alone: got %0d want 0", err_orphan); end
   endtask

   task automatic test_long;
      logic [63:0] rx;
      clear_mon();
      send_frame(40, {$urandom, $urandom}, $urandom, 8, rx);
      send_frame(32, 64'hDEAD_BEEF, $urandom, 8, rx);
      tests++;
      if (pos_words.size() !== 2) begin
         fails++; $display("FAIL long_pos_cnt: got %0d want 2", pos_words.size());
      end else begin
         tests++; if (pos_words[0] !== model_word || pos_errs[0] !== 1'b1) begin
            fails++; $display("FAIL long_frame: word %h err %b want %h 1", pos_words[0], pos_errs[0], model_word); end
         tests++; if (pos_words[1] !== 32'hDEAD_BEEF || pos_errs[1] !== 1'b0) begin
            fails++; $display("FAIL long_recover: word %h err %b want deadbeef 0", pos_words[1], pos_errs[1]); end
      end
      model_word = 32'hDEAD_BEEF;
   endtask

   task automatic test_back_to_back;
      logic [63:0] rx;
      clear_mon();
      send_frame(32, 64'h0000_0001, $urandom, 4, rx);
      send_frame(32, 64'hFFFF_FFFE, $urandom, 8, rx);
      model_word = 32'hFFFF_FFFE;
      tests++; if (neg_cnt !== 2) begin fails++; $display("FAIL b2b_neg_cnt: got %0d want 2", neg_cnt); end
      tests++;
      if (pos_words.size() !== 2) begin
         fails++; $display("FAIL b2b_pos_cnt: got %0d want 2", pos_words.size());
      end else begin
         tests++; if (pos_words[0] !== 32'h0000_0001) begin fails++; $display("FAIL b2b_word0: got %h want 00000001", pos_words[0]); end
         tests++; if (pos_words[1] !== 32'hFFFF_FFFE) begin fails++; $display("FAIL b2b_word1: got %h want fffffffe", pos_words[1]); end
         tests++; if (pos_errs[0] !== 1'b0 || pos_errs[1] !== 1'b0) begin fails++; $display("FAIL b2b_err: got %b%b want 00", pos_errs[0], pos_errs[1]); end
      end
   endtask

   task automatic test_random_frames;
      logic [63:0] rx, data;
      logic [31:0] tw;
      int          n;
      for (int f = 0; f < 8; f++) begin
         clear_mon();
         n    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : 32;
         data = {$urandom, $urandom};
         tw   = $urandom;
         send_frame(n, data, tw, $urandom_range(4, 8), rx);
         if (n == 32) model_word = data[31:0];
         tests++; if (rx !== exp_miso(n, tw)) begin fails++; $display("FAIL rand_miso[%0d]: n %0d got %h want %h", f, n, rx, exp_miso(n, tw)); end
         tests++;
         if (pos_words.size() !== 1 || neg_cnt !== 1) begin
            fails++; $display("FAIL rand_strobes[%0d]: pos %0d neg %0d want 1 1", f, pos_words.size(), neg_cnt);
         end else begin
            tests++; if (pos_words[0] !== model_word) begin fails++; $display("FAIL rand_word[%0d]: n %0d got %h want %h", f, n, pos_words[0], model_word); end
            tests++; if (pos_errs[0] !== (n != 32)) begin fails++; $display("FAIL rand_err[%0d]: n %0d got %b want %b", f, n, pos_errs[0], n != 32); end
         end
      end
   endtask

   task automatic test_reset_mid_frame;
      clear_mon();
      word_in = $urandom;
      @(negedge clk);
      ss = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         mosi = 1'($urandom);
         repeat (4) @(negedge clk); sclk = 1'b1;
         repeat (4) @(negedge clk); sclk = 1'b0;
      end
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      tests++;
      if ({word_out, miso, miso_oe, ss_pos_edge, ss_neg_edge, frame_err} !== 37'h0) begin
         fails++; $display("FAIL rst_async: word %h miso %b oe %b pos %b neg %b err %b want all 0",
                           word_out, miso, miso_oe, ss_pos_edge, ss_neg_edge, frame_err);
      end
      model_word = '0;
      repeat (2) @(negedge clk);
      clear_mon();
      rst = 1'b1;
      repeat (6) @(negedge clk);
      tests++; if (neg_cnt !== 1) begin fails++; $display("FAIL rst_neg_after_release: got %0d want 1", neg_cnt); end
      for (int i = 0; i < 22; i++) begin
         mosi = 1'($urandom);
         repeat (4) @(negedge clk); sclk = 1'b1;
         repeat (4) @(negedge clk); sclk = 1'b0;
      end
      repeat (4) @(negedge clk);
      ss = 1'b1;
      repeat (8) @(negedge clk);
      tests++;
      if (pos_words.size() !== 1) begin
         fails++; $display("FAIL rst_pos_cnt: got %0d want 1", pos_words.size());
      end else begin
         tests++; if (pos_words[0] !== model_word || pos_errs[0] !== 1'b1) begin
            fails++; $display("FAIL rst_residual: word %h err %b want %h 1", pos_words[0], pos_errs[0], model_word); end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_readback();
      test_short();
      test_long();
      test_back_to_back();
      test_random_frames();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
